neopx_frame_seq: RTL and testbench
==================================

NEOPX_FRAME_SEQ -- requirements
Module: neopx_frame_seq

Interface
REQ-001 The module SHALL have parameter NUM_PIXELS, default 64, giving the maximum pixels per frame.
REQ-002 The module SHALL have parameter ADDR_W, default 6, giving the pixel buffer address width; NUM_PIXELS <= 2**ADDR_W.
REQ-003 The module SHALL have parameter LATCH_CYCLES, default 6600, giving the post-frame low time in clocks (>= 55 us at 72 MHz).
REQ-004 The module SHALL have port axis_aclk, input, 1 bit: the single clock.
REQ-005 The module SHALL have port axis_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port start, input, 1 bit: a one-cycle request to send one frame.
REQ-007 The module SHALL have port cfg_pixel_count, input, ADDR_W+1 bits: pixels in the frame, sampled on an accepted start.
REQ-008 The module SHALL have port cfg_continuous, input, 1 bit: when 1, the frame repeats automatically.
REQ-009 The module SHALL have port cfg_brightness, input, 8 bits: global scale, sampled on an accepted start.
REQ-010 The module SHALL have port mem_rd_en, output, 1 bit: pixel buffer read strobe.
REQ-011 The module SHALL have port mem_addr, output, ADDR_W bits: pixel buffer address.
REQ-012 The module SHALL have port mem_rd_data, input, 32 bits: pixel word, valid one cycle after mem_rd_en.
REQ-013 The module SHALL have port m_axis_data, output, 32 bits: scaled pixel word to the bitstream generator (MSB first, GRB[31:8], W[7:0]).
REQ-014 The module SHALL have port m_axis_valid, output, 1 bit.
REQ-015 The module SHALL have port m_axis_ready, input, 1 bit.
REQ-016 The module SHALL have port busy, output, 1 bit: high from an accepted start until done.
REQ-017 The module SHALL have port done, output, 1 bit: a one-cycle pulse at the end of the latch period of a non-continuous frame.

Function
REQ-018 The FSM SHALL use states IDLE, FETCH, WAIT_DATA, PRESENT, LATCH and DONE.
REQ-019 IDLE: start=1 SHALL be accepted, capture count (clamped to NUM_PIXELS) and brightness, clear the pixel index, and go to FETCH; if the clamped count is 0, go to LATCH.
REQ-020 FETCH SHALL drive mem_rd_en=1 for exactly one cycle with mem_addr=index, then go to WAIT_DATA.
REQ-021 WAIT_DATA SHALL register the scaled mem_rd_data into m_axis_data, set m_axis_valid=1, and go to PRESENT.
REQ-022 Latency SHALL be: start sampled at edge k -> mem_rd_en high after edge k -> m_axis_valid high after edge k+2.
REQ-023 PRESENT: m_axis_valid and m_axis_data SHALL hold stable until valid&ready at an edge; at that edge valid drops, the index increments, and the FSM goes to FETCH if index+1 < count, else to LATCH.
REQ-024 LATCH SHALL keep m_axis_valid=0 for exactly LATCH_CYCLES clocks using a 16-bit counter cleared on entry.
REQ-025 At the end of LATCH, if cfg_continuous=1 (sampled at that edge), the FSM SHALL reload the index to 0 and go to FETCH, reusing the captured count and brightness, with no done pulse.
REQ-026 At the end of LATCH, if cfg_continuous=0, the FSM SHALL go to DONE; DONE pulses done=1 for one cycle, clears busy, and returns to IDLE.
REQ-027 start SHALL be ignored whenever the state is not IDLE; no request is queued.
REQ-028 Scaling SHALL apply to each of the 4 bytes: out = (in * (cfg_brightness+1)) >> 8, a 17-bit intermediate truncated to 8 bits; brightness 255 is identity and brightness 0 maps 255 to 0.
REQ-029 The index SHALL never wrap: the maximum index is count-1, and mem_addr stays within 0..NUM_PIXELS-1.
REQ-030 m_axis_ready asserted while valid=0 SHALL have no effect.

Reset
REQ-031 When axis_reset=1, the next edge SHALL set: state IDLE, m_axis_valid 0, m_axis_data 0, mem_rd_en 0, mem_addr 0, busy 0, done 0, and index, latch counter and captured config all 0.
REQ-032 A reset during any state SHALL abandon the frame with no done pulse; an in-flight beat is dropped.

Structure
REQ-033 Package neopx_pkg SHALL hold the FSM state encoding and the timing constants for 72 MHz (LATCH_CYCLES default).
REQ-034 Per-byte scaling SHALL be a combinational sub-module neopx_scale, instantiated 4 times.
REQ-035 No memory SHALL reside in this block; the pixel buffer is external.

Verification
REQ-036 count=3, brightness=255, ready always 1, words 0xA1B2C3D4/0x11223344/0xFF00FF00 -> exactly 3 beats in order, identical data, done pulses 6600 cycles after the last beat.
REQ-037 brightness=127, word 0xFF804000 -> m_axis_data=0x7F402000.
REQ-038 ready held low for 40 cycles in PRESENT -> valid and data are stable all 40 cycles, no extra read, and the beat is accepted once.
REQ-039 count=0 -> no mem_rd_en, no beats, done after 6600+ cycles; count=200 with NUM_PIXELS=64 -> exactly 64 beats, max addr 63.
REQ-040 continuous=1 with count=2 -> beats 0,1, latch, beats 0,1 repeat with no done; clear continuous -> done after the next latch; start pulsed mid-frame is ignored.
REQ-041 axis_reset asserted in PRESENT and in LATCH -> all outputs are at their reset values after the next edge, with no done pulse.

Source files
------------

// File: rtl/neopx_pkg.sv
// Shared definitions for the NeoPixel frame sequencer: FSM encoding and
// latch timing for a 72 MHz fabric clock.
package neopx_pkg;

  // WS2812/SK6812 need >= 55 us low to latch; 6600 clocks is ~91.7 us at 72 MHz.
  localparam int LATCH_CYCLES_72MHZ = 6600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_DATA,
    ST_PRESENT,
    ST_LATCH,
    ST_DONE
  } neopx_state_t;

endpackage

// File: rtl/neopx_frame_seq_if.sv
// Bus bundle between the frame sequencer, the external pixel buffer and the
// downstream bitstream generator (AXI-Stream style valid/ready).
interface neopx_frame_seq_if #(
  parameter int ADDR_W = 6
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;
  logic [31:0]       m_axis_data;
  logic              m_axis_valid;
  logic              m_axis_ready;

  modport master (
    output mem_rd_en, mem_addr, m_axis_data, m_axis_valid,
    input  mem_rd_data, m_axis_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, m_axis_data, m_axis_valid,
    output mem_rd_data, m_axis_ready
  );
endinterface

// File: rtl/neopx_scale.sv
// Combinational brightness scaler for one colour byte:
// out = (in * (brightness + 1)) >> 8, so 255 is identity.
module neopx_scale (
  input  logic [7:0] pix_in,
  input  logic [7:0] brightness,
  output logic [7:0] pix_out
);

  logic [16:0] product;
  logic [8:0]  unused_bits;

  assign product     = {9'd0, pix_in} * ({9'd0, brightness} + 17'd1);
  assign pix_out     = product[15:8];
  assign unused_bits = {product[16], product[7:0]};

endmodule

// File: rtl/neopx_frame_seq.sv
// Frame sequencer: reads pixel words from an external buffer, scales them by a
// global brightness and streams them out, then holds the line low to latch.
module neopx_frame_seq
  import neopx_pkg::*;
#(
  parameter int NUM_PIXELS   = 64,
  parameter int ADDR_W       = 6,
  parameter int LATCH_CYCLES = LATCH_CYCLES_72MHZ
) (
  input  logic              axis_aclk,
  input  logic              axis_reset,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_pixel_count,
  input  logic              cfg_continuous,
  input  logic [7:0]        cfg_brightness,
  neopx_frame_seq_if.master bus,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] MAX_COUNT  = (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [15:0]     LATCH_LAST = 16'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);

  neopx_state_t      state, state_next;
  logic [ADDR_W:0]   index, index_next;
  logic [ADDR_W:0]   count, count_next;
  logic [ADDR_W:0]   clamped_count;
  logic [7:0]        bright, bright_next;
  logic [15:0]       latch_cnt, latch_cnt_next;
  logic              rd_en, rd_en_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [31:0]       data, data_next;
  logic [31:0]       scaled;
  logic              valid, valid_next;
  logic              busy_next, done_next;

  for (genvar b = 0; b < 4; b++) begin : g_scale
    neopx_scale u_scale (
      .pix_in     (bus.mem_rd_data[8*b +: 8]),
      .brightness (bright),
      .pix_out    (scaled[8*b +: 8])
    );
  end

  assign clamped_count = (cfg_pixel_count > MAX_COUNT) ? MAX_COUNT : cfg_pixel_count;

  // Every output is registered, so each transition also sets the values the
  // outputs must show in the destination state.
  always_comb begin
    state_next     = state;
    index_next     = index;
    count_next     = count;
    bright_next    = bright;
    latch_cnt_next = latch_cnt;
    rd_en_next     = 1'b0;
    addr_next      = addr;
    data_next      = data;
    valid_next     = valid;
    busy_next      = busy;
    done_next      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          count_next  = clamped_count;
          bright_next = cfg_brightness;
          index_next  = '0;
          busy_next   = 1'b1;
          if (clamped_count == '0) begin
            state_next     = ST_LATCH;
            latch_cnt_next = '0;
          end else begin
            state_next = ST_FETCH;
            rd_en_next = 1'b1;
            addr_next  = '0;
          end
        end
      end

      ST_FETCH: state_next = ST_WAIT_DATA;

      ST_WAIT_DATA: begin
        data_next  = scaled;
        valid_next = 1'b1;
        state_next = ST_PRESENT;
      end

      ST_PRESENT: begin
        if (valid && bus.m_axis_ready) begin
          valid_next = 1'b0;
          index_next = index + ONE;
          if (index_next < count) begin
            state_next = ST_FETCH;
            rd_en_next = 1'b1;
            addr_next  = index_next[ADDR_W-1:0];
          end else begin
            state_next     = ST_LATCH;
            latch_cnt_next = '0;
          end
        end
      end

      ST_LATCH: begin
        if (latch_cnt == LATCH_LAST) begin
          if (cfg_continuous) begin
            index_next = '0;
            state_next = ST_FETCH;
            rd_en_next = 1'b1;
            addr_next  = '0;
          end else begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end
        end else begin
          latch_cnt_next = latch_cnt + 16'd1;
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state     <= ST_IDLE;
      index     <= '0;
      count     <= '0;
      bright    <= '0;
      latch_cnt <= '0;
      rd_en     <= 1'b0;
      addr      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      index     <= index_next;
      count     <= count_next;
      bright    <= bright_next;
      latch_cnt <= latch_cnt_next;
      rd_en     <= rd_en_next;
      addr      <= addr_next;
      data      <= data_next;
      valid     <= valid_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  assign bus.mem_rd_en    = rd_en;
  assign bus.mem_addr     = addr;
  assign bus.m_axis_data  = data;
  assign bus.m_axis_valid = valid;

endmodule

// File: tb/tb_neopx_frame_seq.sv
// Scoreboard bench for neopx_frame_seq: a pixel-buffer model, a ready driver,
// and a monitor that pops expected beats computed from a byte-wise model.
module tb_neopx_frame_seq;

  localparam int NUM_PIXELS   = 64;
  localparam int ADDR_W       = 6;
  localparam int LATCH_CYCLES = 6600;

  logic            axis_aclk = 1'b0;
  logic            axis_reset;
  logic            start;
  logic [ADDR_W:0] cfg_pixel_count;
  logic            cfg_continuous;
  logic [7:0]      cfg_brightness;
  logic            busy;
  logic            done;

  neopx_frame_seq_if #(.ADDR_W(ADDR_W)) bus ();

  neopx_frame_seq #(
    .NUM_PIXELS   (NUM_PIXELS),
    .ADDR_W       (ADDR_W),
    .LATCH_CYCLES (LATCH_CYCLES)
  ) dut (
    .axis_aclk       (axis_aclk),
    .axis_reset      (axis_reset),
    .start           (start),
    .cfg_pixel_count (cfg_pixel_count),
    .cfg_continuous  (cfg_continuous),
    .cfg_brightness  (cfg_brightness),
    .bus             (bus),
    .busy            (busy),
    .done            (done)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          beats = 0;
  int          reads = 0;
  int          done_count = 0;
  int          max_addr = 0;
  int          last_beat_edge = 0;
  int          done_edge = 0;
  int          start_edge = 0;
  int          ready_mode = 1;
  logic [31:0] pix_mem [NUM_PIXELS];
  logic [31:0] sb [$];
  logic        prev_stall;
  logic [31:0] prev_data;

  initial forever #5 axis_aclk = ~axis_aclk;

  initial forever begin
    @(posedge axis_aclk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: each byte scaled independently by (b+1)/256, truncated.
  function automatic logic [31:0] scaleWord(input logic [31:0] w, input int b);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      int byte_v;
      int o;
      byte_v = int'((w >> (8*k)) & 32'hFF);
      o = (byte_v * (b + 1)) / 256;
      r[8*k +: 8] = 8'(o);
    end
    return r;
  endfunction

  task automatic pushFrame(input int count, input int b);
    int n;
    n = (count > NUM_PIXELS) ? NUM_PIXELS : count;
    for (int i = 0; i < n; i++) sb.push_back(scaleWord(pix_mem[i], b));
  endtask

  task automatic applyStimulus(input int count, input int b, input logic cont);
    pushFrame(count, b);
    @(negedge axis_aclk);
    start           = 1'b1;
    cfg_pixel_count = (ADDR_W+1)'(count);
    cfg_brightness  = 8'(b);
    cfg_continuous  = cont;
    @(negedge axis_aclk);
    start      = 1'b0;
    start_edge = cyc;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge axis_aclk);
  endtask

  task automatic waitValid(input int budget, input string name);
    int t = 0;
    while (!bus.m_axis_valid && t < budget) begin
      @(negedge axis_aclk);
      t++;
    end
    checkOutput(name, {31'd0, bus.m_axis_valid}, 32'd1);
  endtask

  task automatic waitBeats(input int target, input int budget, input string name);
    int t = 0;
    while (beats < target && t < budget) begin
      @(negedge axis_aclk);
      #1;
      t++;
    end
    checkOutput(name, beats, target);
  endtask

  task automatic waitDone(input int budget, input string name);
    int dc = done_count;
    int t = 0;
    while (done_count == dc && t < budget) begin
      @(negedge axis_aclk);
      #1;
      t++;
    end
    checkOutput(name, done_count, dc + 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, bus.m_axis_valid}, 32'd0);
    checkOutput({tag, "_data"}, bus.m_axis_data, 32'd0);
    checkOutput({tag, "_rd_en"}, {31'd0, bus.mem_rd_en}, 32'd0);
    checkOutput({tag, "_addr"}, {26'd0, bus.mem_addr}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // Synchronous pixel buffer: data appears one cycle after the read strobe.
  initial begin
    logic              pend;
    logic [ADDR_W-1:0] a;
    bus.mem_rd_data = '0;
    forever begin
      @(negedge axis_aclk);
      pend = bus.mem_rd_en;
      a    = bus.mem_addr;
      @(posedge axis_aclk);
      #1;
      if (pend) bus.mem_rd_data = pix_mem[a];
    end
  end

  initial begin
    bus.m_axis_ready = 1'b0;
    forever begin
      @(posedge axis_aclk);
      #2;
      case (ready_mode)
        0:       bus.m_axis_ready = 1'b0;
        1:       bus.m_axis_ready = 1'b1;
        default: bus.m_axis_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: a beat is counted when valid&ready is seen, since it is taken at the next edge.
  initial begin
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge axis_aclk);
      if (!axis_reset) begin
        if (prev_stall) begin
          checkOutput("hold_valid", {31'd0, bus.m_axis_valid}, 32'd1);
          checkOutput("hold_data", bus.m_axis_data, prev_data);
        end
        if (bus.m_axis_valid && bus.m_axis_ready) begin
          beats++;
          last_beat_edge = cyc + 1;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_beat actual=0x%08h expected=none", bus.m_axis_data);
          end else begin
            checkOutput("beat_data", bus.m_axis_data, sb.pop_front());
          end
        end
        if (bus.mem_rd_en) begin
          reads++;
          if (int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
        end
        if (done) begin
          done_count++;
          done_edge = cyc;
        end
        prev_stall = bus.m_axis_valid && !bus.m_axis_ready;
        prev_data  = bus.m_axis_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int b0, r0, d0, gap_ref, lat_cnt;
    axis_reset      = 1'b1;
    start           = 1'b0;
    cfg_pixel_count = '0;
    cfg_continuous  = 1'b0;
    cfg_brightness  = '0;
    for (int i = 0; i < NUM_PIXELS; i++) pix_mem[i] = $urandom;

    waitCycles(3);
    checkResetOutputs("reset");
    axis_reset = 1'b0;

    // Three-word frame at full brightness: identity data and latch timing.
    pix_mem[0] = 32'hA1B2C3D4;
    pix_mem[1] = 32'h11223344;
    pix_mem[2] = 32'hFF00FF00;
    b0 = beats;
    applyStimulus(3, 255, 1'b0);
    checkOutput("lat_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    checkOutput("lat_addr", {26'd0, bus.mem_addr}, 32'd0);
    checkOutput("lat_busy", {31'd0, busy}, 32'd1);
    @(negedge axis_aclk);
    checkOutput("lat_rd_pulse", {31'd0, bus.mem_rd_en}, 32'd0);
    checkOutput("lat_valid_early", {31'd0, bus.m_axis_valid}, 32'd0);
    @(negedge axis_aclk);
    checkOutput("lat_valid", {31'd0, bus.m_axis_valid}, 32'd1);
    checkOutput("identity_first", bus.m_axis_data, 32'hA1B2C3D4);
    waitDone(LATCH_CYCLES + 100, "frame3_done");
    checkOutput("frame3_beats", beats - b0, 3);
    checkOutput("frame3_latch", done_edge - last_beat_edge, LATCH_CYCLES);
    checkOutput("frame3_sb_empty", sb.size(), 0);
    checkOutput("frame3_busy_off", {31'd0, busy}, 32'd0);
    @(negedge axis_aclk);
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);

    // Half brightness on a single known word.
    pix_mem[0] = 32'hFF804000;
    applyStimulus(1, 127, 1'b0);
    waitValid(10, "b127_valid");
    checkOutput("b127_data", bus.m_axis_data, 32'h7F402000);
    waitDone(LATCH_CYCLES + 100, "b127_done");

    // Back-pressure: ready low for 40 cycles while presenting.
    ready_mode = 0;
    b0 = beats;
    applyStimulus(2, $urandom_range(0, 255), 1'b0);
    waitValid(10, "stall_valid");
    r0 = reads;
    waitCycles(40);
    checkOutput("stall_no_read", reads, r0);
    checkOutput("stall_no_beat", beats, b0);
    ready_mode = 1;
    waitDone(LATCH_CYCLES + 100, "stall_done");
    checkOutput("stall_beats", beats - b0, 2);

    // Empty frame: no reads, no beats, just the latch period.
    r0 = reads;
    b0 = beats;
    applyStimulus(0, 200, 1'b0);
    waitDone(LATCH_CYCLES + 100, "zero_done");
    checkOutput("zero_reads", reads, r0);
    checkOutput("zero_beats", beats, b0);
    checkOutput("zero_latch", done_edge - start_edge, LATCH_CYCLES);

    // Oversized count clamps to the buffer size.
    for (int i = 0; i < NUM_PIXELS; i++) pix_mem[i] = $urandom;
    ready_mode = 2;
    max_addr = 0;
    r0 = reads;
    b0 = beats;
    applyStimulus(127, $urandom_range(0, 255), 1'b0);
    waitDone(LATCH_CYCLES + 2000, "clamp_done");
    checkOutput("clamp_beats", beats - b0, NUM_PIXELS);
    checkOutput("clamp_reads", reads - r0, NUM_PIXELS);
    checkOutput("clamp_max_addr", max_addr, NUM_PIXELS - 1);
    checkOutput("clamp_sb_empty", sb.size(), 0);

    // Continuous mode repeats, ignores a mid-frame start, stops when cleared.
    ready_mode = 1;
    b0 = beats;
    d0 = done_count;
    lat_cnt = $urandom_range(0, 255);
    applyStimulus(2, lat_cnt, 1'b1);
    pushFrame(2, lat_cnt);
    start = 1'b1;
    cfg_pixel_count = 7'd5;
    @(negedge axis_aclk);
    start = 1'b0;
    cfg_pixel_count = 7'd2;
    waitBeats(b0 + 2, 50, "cont_frame1");
    gap_ref = last_beat_edge;
    waitBeats(b0 + 3, LATCH_CYCLES + 100, "cont_restart");
    checkOutput("cont_gap", last_beat_edge - gap_ref, LATCH_CYCLES + 3);
    waitBeats(b0 + 4, 50, "cont_frame2");
    checkOutput("cont_no_done", done_count, d0);
    cfg_continuous = 1'b0;
    waitDone(LATCH_CYCLES + 100, "cont_stop_done");
    checkOutput("cont_beats", beats - b0, 4);
    checkOutput("cont_latch", done_edge - last_beat_edge, LATCH_CYCLES);
    checkOutput("cont_sb_empty", sb.size(), 0);

    // Reset while presenting a stalled beat.
    ready_mode = 0;
    applyStimulus(3, 200, 1'b0);
    waitValid(10, "rstp_valid");
    axis_reset = 1'b1;
    @(negedge axis_aclk);
    checkResetOutputs("rst_present");
    sb.delete();
    axis_reset = 1'b0;
    ready_mode = 1;
    d0 = done_count;
    waitCycles(20);
    checkOutput("rst_present_no_done", done_count, d0);

    // Reset in the middle of the latch period.
    b0 = beats;
    applyStimulus(1, 255, 1'b0);
    waitBeats(b0 + 1, 20, "rstl_beat");
    waitCycles(100);
    checkOutput("rstl_busy", {31'd0, busy}, 32'd1);
    axis_reset = 1'b1;
    @(negedge axis_aclk);
    checkResetOutputs("rst_latch");
    axis_reset = 1'b0;
    d0 = done_count;
    waitCycles(LATCH_CYCLES + 100);
    checkOutput("rst_latch_no_done", done_count, d0);

    // Randomised frames with random back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NUM_PIXELS; i++) pix_mem[i] = $urandom;
      b0 = beats;
      r0 = $urandom_range(1, 20);
      applyStimulus(r0, $urandom_range(0, 255), 1'b0);
      waitDone(LATCH_CYCLES + 500, "rand_done");
      checkOutput("rand_beats", beats - b0, r0);
      checkOutput("rand_latch", done_edge - last_beat_edge, LATCH_CYCLES);
      checkOutput("rand_sb_empty", sb.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
